// File: rtl/rtc_timekeeper.sv
// Purpose : parametrised real-time clock; divides clk to a 1 Hz tick and keeps a binary 24 h
//           time of day with run/pause, validated time load, one alarm with sticky flag, 12 h display.
// Latency : time, tick_1hz, load_err and alarm_flag update on the edge after their cause; the hours
//           and pm outputs are combinational from the registered hour.
// Backpressure: none; the block always accepts load/alarm_set strobes and never stalls.
//
// Ports:
//   clk, reset        clock; synchronous active-high reset (highest priority)
//   run               1 = prescaler and time advance, 0 = both frozen
//   load, load_h/m/s  1-cycle strobe to set the time (rejected if any field is out of range)
//   alarm_set, alarm_h/m   1-cycle strobe to capture the alarm time (same range check)
//   load_err          1-cycle pulse when a load and/or alarm_set is rejected
//   alarm_en, alarm_ack    alarm arm; clear of the sticky flag
//   alarm_flag        sticky, set when the alarm fires on a tick
//   fmt_12h           selects 12 h display on hours
//   hours, pm, minutes, seconds   displayed time
//   tick_1hz          1-cycle pulse after each seconds advance
//   io_oeb            pad output enables, all driven low (pads are outputs)
//
// CLK_HZ must be >= 2 and 2**PRESCALE_W must be >= CLK_HZ.

module rtc_timekeeper #(
    parameter int CLK_HZ     = 50_000_000,
    parameter int PRESCALE_W = 26
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        load,
    input  logic [4:0]  load_h,
    input  logic [5:0]  load_m,
    input  logic [5:0]  load_s,
    output logic        load_err,
    input  logic        alarm_set,
    input  logic [4:0]  alarm_h,
    input  logic [5:0]  alarm_m,
    input  logic        alarm_en,
    input  logic        alarm_ack,
    output logic        alarm_flag,
    input  logic        fmt_12h,
    output logic [5:0]  hours,
    output logic        pm,
    output logic [5:0]  minutes,
    output logic [5:0]  seconds,
    output logic        tick_1hz,
    output logic [18:0] io_oeb
);

    localparam logic [PRESCALE_W-1:0] PRESCALE_MAX = PRESCALE_W'(CLK_HZ - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PRESCALE_W-1:0] prescaler;
    logic [4:0]            hour_q;
    logic [5:0]            min_q;
    logic [5:0]            sec_q;
    logic [4:0]            alarm_h_q;
    logic [5:0]            alarm_m_q;

    // ------------------------------------------------------------------
    // Strobe qualification
    // ------------------------------------------------------------------
    logic load_ok;
    logic load_bad;
    logic alarm_ok;
    logic alarm_bad;

    always_comb begin
        load_ok   = 1'b0;
        load_bad  = 1'b0;
        alarm_ok  = 1'b0;
        alarm_bad = 1'b0;
        if (load) begin
            if ((load_h <= 5'd23) && (load_m <= 6'd59) && (load_s <= 6'd59)) begin
                load_ok = 1'b1;
            end else begin
                load_bad = 1'b1;
            end
        end
        if (alarm_set) begin
            if ((alarm_h <= 5'd23) && (alarm_m <= 6'd59)) begin
                alarm_ok = 1'b1;
            end else begin
                alarm_bad = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Prescaler wrap and tick qualification
    // ------------------------------------------------------------------
    logic tick_due;   // prescaler wraps on this edge
    logic tick_take;  // time actually advances (a valid load overrides the tick)

    always_comb begin
        tick_due  = run && (prescaler == PRESCALE_MAX);
        tick_take = tick_due && !load_ok;
    end

    // ------------------------------------------------------------------
    // Next time of day with carry chain (binary)
    // ------------------------------------------------------------------
    logic [4:0] next_hour;
    logic [5:0] next_min;
    logic [5:0] next_sec;

    always_comb begin
        next_hour = hour_q;
        next_min  = min_q;
        next_sec  = sec_q + 6'd1;
        if (sec_q == 6'd59) begin
            next_sec = 6'd0;
            if (min_q == 6'd59) begin
                next_min  = 6'd0;
                next_hour = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
            end else begin
                next_min = min_q + 6'd1;
            end
        end
    end

    // The alarm compares against the time about to become visible, so a load
    // (which suppresses tick_take) can never fire it.
    logic alarm_fire;

    always_comb begin
        alarm_fire = tick_take && alarm_en &&
                     (next_sec == 6'd0) &&
                     (next_min == alarm_m_q) &&
                     (next_hour == alarm_h_q);
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler  <= '0;
            hour_q     <= 5'd0;
            min_q      <= 6'd0;
            sec_q      <= 6'd0;
            alarm_h_q  <= 5'd0;
            alarm_m_q  <= 6'd0;
            alarm_flag <= 1'b0;
            tick_1hz   <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            // Prescaler: a valid load restarts the second, otherwise count while running.
            if (load_ok) begin
                prescaler <= '0;
            end else if (run) begin
                prescaler <= tick_due ? '0 : prescaler + 1'b1;
            end

            // Time of day
            if (load_ok) begin
                hour_q <= load_h;
                min_q  <= load_m;
                sec_q  <= load_s;
            end else if (tick_take) begin
                hour_q <= next_hour;
                min_q  <= next_min;
                sec_q  <= next_sec;
            end

            // Alarm time capture
            if (alarm_ok) begin
                alarm_h_q <= alarm_h;
                alarm_m_q <= alarm_m;
            end

            // Sticky alarm flag: a fire beats a coincident acknowledge.
            if (alarm_fire) begin
                alarm_flag <= 1'b1;
            end else if (alarm_ack) begin
                alarm_flag <= 1'b0;
            end

            tick_1hz <= tick_take;
            // Both strobes rejected together still yield one single-cycle pulse.
            load_err <= load_bad || alarm_bad;
        end
    end

    // ------------------------------------------------------------------
    // Display path (combinational from the registered hour)
    // ------------------------------------------------------------------
    logic [4:0] hour_12;

    always_comb begin
        hour_12 = hour_q;
        if (hour_q == 5'd0) begin
            hour_12 = 5'd12;
        end else if (hour_q > 5'd12) begin
            hour_12 = hour_q - 5'd12;
        end
    end

    assign hours   = {1'b0, (fmt_12h ? hour_12 : hour_q)};
    assign pm      = (hour_q >= 5'd12);
    assign minutes = min_q;
    assign seconds = sec_q;
    assign io_oeb  = '0;

endmodule

// File: tb/tb_rtc_timekeeper.sv
// Purpose : directed self-checking bench for rtc_timekeeper (CLK_HZ=4 main instance,
//           CLK_HZ=1000 instance for exact first-tick timing with a tight prescaler width).
// Latency : inputs driven 1 time unit after a rising edge, outputs sampled 1 unit after the next.
// Backpressure: not applicable.

module tb_rtc_timekeeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main instance (CLK_HZ = 4)
    logic        reset, run, load, alarm_set, alarm_en, alarm_ack, fmt_12h;
    logic [4:0]  load_h, alarm_h;
    logic [5:0]  load_m, load_s, alarm_m;
    logic        load_err, alarm_flag, pm, tick_1hz;
    logic [5:0]  hours, minutes, seconds;
    logic [18:0] io_oeb;

    rtc_timekeeper #(.CLK_HZ(4), .PRESCALE_W(2)) u_dut (
        .clk(clk), .reset(reset), .run(run),
        .load(load), .load_h(load_h), .load_m(load_m), .load_s(load_s), .load_err(load_err),
        .alarm_set(alarm_set), .alarm_h(alarm_h), .alarm_m(alarm_m),
        .alarm_en(alarm_en), .alarm_ack(alarm_ack), .alarm_flag(alarm_flag),
        .fmt_12h(fmt_12h), .hours(hours), .pm(pm), .minutes(minutes), .seconds(seconds),
        .tick_1hz(tick_1hz), .io_oeb(io_oeb)
    );

    // Second instance (CLK_HZ = 1000, 10-bit prescaler)
    logic        reset2, run2;
    logic        load_err2, alarm_flag2, pm2, tick2;
    logic [5:0]  hours2, minutes2, seconds2;
    logic [18:0] io_oeb2;

    rtc_timekeeper #(.CLK_HZ(1000), .PRESCALE_W(10)) u_dut_1k (
        .clk(clk), .reset(reset2), .run(run2),
        .load(1'b0), .load_h(5'd0), .load_m(6'd0), .load_s(6'd0), .load_err(load_err2),
        .alarm_set(1'b0), .alarm_h(5'd0), .alarm_m(6'd0),
        .alarm_en(1'b0), .alarm_ack(1'b0), .alarm_flag(alarm_flag2),
        .fmt_12h(1'b0), .hours(hours2), .pm(pm2), .minutes(minutes2), .seconds(seconds2),
        .tick_1hz(tick2), .io_oeb(io_oeb2)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk_time(input string tag, input int h, input int m, input int s);
        chk({tag, ".h"}, 32'(hours), 32'(h));
        chk({tag, ".m"}, 32'(minutes), 32'(m));
        chk({tag, ".s"}, 32'(seconds), 32'(s));
    endtask

    task automatic do_load(input int h, input int m, input int s);
        load   = 1'b1;
        load_h = 5'(h);
        load_m = 6'(m);
        load_s = 6'(s);
        cyc(1);
        load   = 1'b0;
    endtask

    int first_tick;

    initial begin
        reset = 1'b1; run = 1'b0; load = 1'b0; alarm_set = 1'b0;
        alarm_en = 1'b0; alarm_ack = 1'b0; fmt_12h = 1'b0;
        load_h = '0; load_m = '0; load_s = '0; alarm_h = '0; alarm_m = '0;
        reset2 = 1'b1; run2 = 1'b0;

        // ---- Reset state ----
        cyc(2);
        chk_time("rst", 0, 0, 0);
        chk("rst.tick", 32'(tick_1hz), 0);
        chk("rst.err", 32'(load_err), 0);
        chk("rst.flag", 32'(alarm_flag), 0);
        chk("rst.pm", 32'(pm), 0);
        chk("rst.oeb", 32'(io_oeb), 0);

        // ---- Divider: ticks on cycles 4 and 8 ----
        reset = 1'b0;
        run   = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            cyc(1);
            chk($sformatf("run.tick%0d", i), 32'(tick_1hz), ((i == 4) || (i == 8)) ? 1 : 0);
        end
        chk("run.sec", 32'(seconds), 2);

        // ---- Pause: nothing moves ----
        run = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            cyc(1);
            chk($sformatf("pause.tick%0d", i), 32'(tick_1hz), 0);
        end
        chk("pause.sec", 32'(seconds), 2);

        // ---- Day rollover, pm and 12 h display ----
        do_load(23, 59, 58);
        chk_time("ld1", 23, 59, 58);
        chk("ld1.tick", 32'(tick_1hz), 0);
        run = 1'b1;
        cyc(4);
        chk_time("roll1", 23, 59, 59);
        chk("roll1.pm", 32'(pm), 1);
        fmt_12h = 1'b1;
        #1;
        chk("roll1.h12", 32'(hours), 11);
        cyc(4);
        chk("roll2.h12", 32'(hours), 12);
        chk("roll2.pm", 32'(pm), 0);
        fmt_12h = 1'b0;
        #1;
        chk_time("roll2", 0, 0, 0);

        // ---- Invalid load ----
        run = 1'b0;
        do_load(0, 60, 0);
        chk("bad.err", 32'(load_err), 1);
        chk_time("bad", 0, 0, 0);
        cyc(1);
        chk("bad.err_end", 32'(load_err), 0);

        // ---- Invalid load and invalid alarm together: single pulse ----
        alarm_set = 1'b1; alarm_h = 5'd3; alarm_m = 6'd60;
        do_load(24, 0, 0);
        alarm_set = 1'b0;
        chk("both.err", 32'(load_err), 1);
        cyc(1);
        chk("both.err_end", 32'(load_err), 0);
        chk_time("both", 0, 0, 0);

        // ---- Load coincident with tick edge ----
        run = 1'b1;
        cyc(3);
        chk("coin.pre", 32'(tick_1hz), 0);
        do_load(10, 20, 30);
        chk_time("coin", 10, 20, 30);
        chk("coin.tick", 32'(tick_1hz), 0);
        fmt_12h = 1'b1;
        #1;
        chk("coin.h12", 32'(hours), 10);
        fmt_12h = 1'b0;
        cyc(3);
        chk("coin.t3", 32'(tick_1hz), 0);
        cyc(1);
        chk("coin.t4", 32'(tick_1hz), 1);
        chk_time("coin.adv", 10, 20, 31);

        // ---- Alarm ----
        run = 1'b0;
        alarm_set = 1'b1; alarm_h = 5'd7; alarm_m = 6'd15; alarm_en = 1'b1;
        cyc(1);
        alarm_set = 1'b0;
        do_load(7, 15, 0);
        chk("alm.loadnofire", 32'(alarm_flag), 0);
        do_load(7, 14, 59);
        run = 1'b1;
        cyc(3);
        chk("alm.pre", 32'(alarm_flag), 0);
        alarm_ack = 1'b1;
        cyc(1);
        alarm_ack = 1'b0;
        chk("alm.fire_ack", 32'(alarm_flag), 1);
        chk_time("alm", 7, 15, 0);
        run = 1'b0;
        cyc(3);
        chk("alm.held", 32'(alarm_flag), 1);
        alarm_ack = 1'b1;
        cyc(1);
        alarm_ack = 1'b0;
        chk("alm.ack", 32'(alarm_flag), 0);

        alarm_en = 1'b0;
        do_load(7, 14, 59);
        run = 1'b1;
        cyc(4);
        chk_time("alm_dis", 7, 15, 0);
        chk("alm_dis.flag", 32'(alarm_flag), 0);

        // ---- Reset mid-second ----
        run = 1'b0;
        do_load(12, 34, 56);
        chk("mid.pm", 32'(pm), 1);
        fmt_12h = 1'b1;
        #1;
        chk("mid.h12", 32'(hours), 12);
        fmt_12h = 1'b0;
        run = 1'b1;
        cyc(2);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        chk_time("mid.rst", 0, 0, 0);
        chk("mid.rst_tick", 32'(tick_1hz), 0);
        for (int i = 1; i <= 4; i++) begin
            cyc(1);
            chk($sformatf("mid.tick%0d", i), 32'(tick_1hz), (i == 4) ? 1 : 0);
        end
        chk("mid.sec", 32'(seconds), 1);

        // ---- Exact first tick on the 1 kHz instance ----
        reset2 = 1'b1;
        cyc(1);
        chk("k.rst_tick", 32'(tick2), 0);
        reset2 = 1'b0;
        run2   = 1'b1;
        first_tick = 0;
        for (int i = 1; i <= 1100 && first_tick == 0; i++) begin
            cyc(1);
            if (tick2) first_tick = i;
        end
        chk("k.first_tick", 32'(first_tick), 1000);
        chk("k.sec", 32'(seconds2), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
